// File: rtl/uart_transmit_if.sv
// Write-side and serial-side signals of the UART transmitter, grouped as one bus.
// The master drives bytes and the baud enable; the slave (transmitter) returns status and TXD.
interface uart_transmit_if #(
    parameter int FIFO_AW = 2
);
    logic [7:0]       data;
    logic             wr_en;
    logic             full;
    logic [FIFO_AW:0] level;
    logic             overrun;
    logic             trans_en;
    logic             txd;
    logic             txd_busy;

    modport master (
        output data, wr_en, trans_en,
        input  full, level, overrun, txd, txd_busy
    );

    modport slave (
        input  data, wr_en, trans_en,
        output full, level, overrun, txd, txd_busy
    );
endinterface

// File: rtl/uart_transmit.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (1 or 2 stop bits).
// Bit timing is driven entirely by the single-cycle baud enable trans_en.
module uart_transmit #(
    parameter int FIFO_AW   = 2,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_transmit_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]    level_reg;
    logic                overrun_reg;
    logic                txd_reg, txd_next;
    logic [7:0]          shift_reg, shift_next;
    logic [2:0]          bit_cnt_reg, bit_cnt_next;
    logic                stop_cnt_reg, stop_cnt_next;
    logic                fifo_empty, fifo_full;
    logic                push, pop;

    // Full/empty come from the registered level, so a byte written this cycle
    // is never visible to a pop decided on the same edge.
    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = (level_reg == (FIFO_AW+1)'(DEPTH));
    assign push       = bus.wr_en && !fifo_full;

    always_comb begin
        state_next    = state_reg;
        txd_next      = txd_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        pop           = 1'b0;
        if (bus.trans_en) begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        txd_next   = 1'b0;
                        state_next = START;
                    end
                end
                START: begin
                    txd_next     = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = 3'd0;
                    state_next   = DATA;
                end
                DATA: begin
                    if (bit_cnt_reg == 3'd7) begin
                        txd_next      = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = STOP;
                    end else begin
                        txd_next     = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                STOP: begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = mem[rd_ptr_reg];
                            txd_next   = 1'b0;
                            state_next = START;
                        end else begin
                            txd_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            txd_reg      <= 1'b1;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            txd_reg      <= txd_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (bus.wr_en && fifo_full) overrun_reg <= 1'b1;
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= bus.data;
    end

    assign bus.full     = fifo_full;
    assign bus.level    = level_reg;
    assign bus.overrun  = overrun_reg;
    assign bus.txd      = txd_reg;
    assign bus.txd_busy = (state_reg != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: two instances (1 and 2 stop bits) driven identically and
// checked against a queue-based model of the byte stream and the serial bit stream.
module tb_uart_transmit;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_transmit_if #(.FIFO_AW(AW)) ifc1 ();
    uart_transmit_if #(.FIFO_AW(AW)) ifc2 ();

    uart_transmit #(.FIFO_AW(AW), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    uart_transmit #(.FIFO_AW(AW), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    // Model: queued bytes, remaining bits of the frame on the wire, expected TXD.
    logic [7:0] mq [2][$];
    bit         mf [2][$];
    bit         act [2];
    bit         m_txd [2];
    bit         m_ovr [2];

    int compared   = 0;
    int mismatched = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mf[k].delete();
            act[k]   = 1'b0;
            m_txd[k] = 1'b1;
            m_ovr[k] = 1'b0;
        end
    endtask

    // One clock edge of the model; k selects 1 (k=0) or 2 (k=1) stop bits.
    task automatic model_edge(input logic we, input logic [7:0] d, input logic te);
        for (int k = 0; k < 2; k++) begin
            int pre;
            logic [7:0] b;
            pre = mq[k].size();
            if (te) begin
                if (mf[k].size() == 0) begin
                    if (pre != 0) begin
                        b = mq[k].pop_front();
                        mf[k].push_back(1'b0);
                        for (int i = 0; i < 8; i++) mf[k].push_back(b[i]);
                        for (int s = 0; s <= k; s++) mf[k].push_back(1'b1);
                        act[k] = 1'b1;
                    end else begin
                        act[k] = 1'b0;
                    end
                end
                if (mf[k].size() != 0) m_txd[k] = mf[k].pop_front();
                else                   m_txd[k] = 1'b1;
            end
            if (we) begin
                if (pre == DEPTH) m_ovr[k] = 1'b1;
                else              mq[k].push_back(d);
            end
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d, input logic te);
        ifc1.wr_en = we; ifc1.data = d; ifc1.trans_en = te;
        ifc2.wr_en = we; ifc2.data = d; ifc2.trans_en = te;
        @(posedge clk);
        model_edge(we, d, te);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        ifc1.wr_en = 1'b0; ifc1.data = 8'h00; ifc1.trans_en = 1'b0;
        ifc2.wr_en = 1'b0; ifc2.data = 8'h00; ifc2.trans_en = 1'b0;
        #20;
        if ({ifc1.txd, ifc1.txd_busy, ifc1.level, ifc1.full, ifc1.overrun} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_in txd/busy/level/full/ovr got=%b exp=1_0_000_0_0",
                     {ifc1.txd, ifc1.txd_busy, ifc1.level, ifc1.full, ifc1.overrun});
        end
        compared++;
        #80;
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step(1'b0, 8'h00, 1'b0);
            if ({ifc1.txd, ifc1.txd_busy, ifc1.level, ifc1.full} !== 6'b1_0_000_0 ||
                {ifc2.txd, ifc2.txd_busy} !== 2'b10) begin
                mismatched++;
                $display("FAIL reset_idle cyc=%0d got=%b/%b exp=100000/10", c,
                         {ifc1.txd, ifc1.txd_busy, ifc1.level, ifc1.full}, {ifc2.txd, ifc2.txd_busy});
            end
            compared++;
        end
    endtask

    task automatic test_basic_frames();
        logic [7:0] bytes [2];
        logic [9:0] pats  [2];
        logic [9:0] got;
        bytes[0] = 8'h55; pats[0] = 10'b1010101010;
        bytes[1] = 8'hA3; pats[1] = 10'b1101000110;
        for (int t = 0; t < 2; t++) begin
            got = '0;
            step(1'b1, bytes[t], 1'b0);
            for (int i = 0; i < 12; i++) begin
                for (int c = 0; c < 10; c++) begin
                    step(1'b0, 8'h00, c == 0);
                    if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                        mismatched++;
                        $display("FAIL basic_txd byte=%h bit=%0d cyc=%0d got=%b%b exp=%b%b",
                                 bytes[t], i, c, ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
                    end
                    compared++;
                    if (ifc1.txd_busy !== (act[0] || mq[0].size() != 0)) begin
                        mismatched++;
                        $display("FAIL basic_busy byte=%h bit=%0d got=%b exp=%b",
                                 bytes[t], i, ifc1.txd_busy, act[0] || mq[0].size() != 0);
                    end
                    compared++;
                end
                if (i < 10) got[i] = ifc1.txd;
            end
            if (got !== pats[t]) begin
                mismatched++;
                $display("FAIL basic_pattern byte=%h got=%b exp=%b", bytes[t], got, pats[t]);
            end
            compared++;
            if ({ifc1.txd_busy, ifc2.txd_busy} !== 2'b00) begin
                mismatched++;
                $display("FAIL basic_idle byte=%h busy=%b exp=00", bytes[t], {ifc1.txd_busy, ifc2.txd_busy});
            end
            compared++;
        end
    endtask

    task automatic test_random();
        int cd = 0;
        int c;
        logic te, we;
        logic [7:0] d;
        for (c = 0; c < 3000; c++) begin
            te = 1'b0;
            if (cd == 0) begin te = 1'b1; cd = $urandom_range(3, 12); end
            else cd--;
            we = (mq[0].size() < 3) && (mq[1].size() < 3) && ($urandom_range(0, 15) == 0);
            d  = 8'($urandom);
            step(we, d, te);
            if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                mismatched++;
                $display("FAIL rand_txd cyc=%0d got=%b%b exp=%b%b", c, ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
            end
            compared++;
            if (ifc1.level !== 3'(mq[0].size()) || ifc2.level !== 3'(mq[1].size()) ||
                ifc1.txd_busy !== (act[0] || mq[0].size() != 0)) begin
                mismatched++;
                $display("FAIL rand_level cyc=%0d got=%0d/%0d busy=%b exp=%0d/%0d busy=%b", c,
                         ifc1.level, ifc2.level, ifc1.txd_busy, mq[0].size(), mq[1].size(),
                         act[0] || mq[0].size() != 0);
            end
            compared++;
        end
        for (c = 0; c < 2000 && (act[0] || act[1] || mq[0].size() != 0 || mq[1].size() != 0); c++) begin
            step(1'b0, 8'h00, (c % 4) == 0);
            if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                mismatched++;
                $display("FAIL rand_drain cyc=%0d got=%b%b exp=%b%b", c, ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
            end
            compared++;
        end
        if (act[0] || act[1] || {ifc1.txd_busy, ifc2.txd_busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL rand_drain_timeout busy=%b exp=00", {ifc1.txd_busy, ifc2.txd_busy});
        end
        compared++;
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        if (ifc1.level !== 3'd3 || ifc2.level !== 3'd3) begin
            mismatched++;
            $display("FAIL b2b_level3 got=%0d/%0d exp=3/3", ifc1.level, ifc2.level);
        end
        compared++;
        for (int i = 0; i < 38; i++) begin
            for (int c = 0; c < 10; c++) begin
                step(1'b0, 8'h00, c == 0);
                if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                    mismatched++;
                    $display("FAIL b2b_txd bit=%0d cyc=%0d got=%b%b exp=%b%b", i, c,
                             ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
                end
                compared++;
                if (ifc1.level !== 3'(mq[0].size()) || ifc2.level !== 3'(mq[1].size())) begin
                    mismatched++;
                    $display("FAIL b2b_level bit=%0d got=%0d/%0d exp=%0d/%0d", i,
                             ifc1.level, ifc2.level, mq[0].size(), mq[1].size());
                end
                compared++;
            end
        end
        if ({ifc1.txd_busy, ifc2.txd_busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_idle busy=%b exp=00", {ifc1.txd_busy, ifc2.txd_busy});
        end
        compared++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if (i == 3 && {ifc1.level, ifc1.full, ifc1.overrun, ifc2.level, ifc2.full} !== {3'd4, 1'b1, 1'b0, 3'd4, 1'b1}) begin
                mismatched++;
                $display("FAIL ovr_full4 got=%b exp=100_1_0_100_1",
                         {ifc1.level, ifc1.full, ifc1.overrun, ifc2.level, ifc2.full});
            end
            if (i == 4 && {ifc1.level, ifc1.overrun, ifc2.level, ifc2.overrun} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
                mismatched++;
                $display("FAIL ovr_drop5 got=%b exp=100_1_100_1",
                         {ifc1.level, ifc1.overrun, ifc2.level, ifc2.overrun});
            end
            if (i >= 3) compared++;
        end
        for (int c = 0; c < 300; c++) begin
            step(1'b0, 8'h00, (c % 6) == 0);
            if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                mismatched++;
                $display("FAIL ovr_txd cyc=%0d got=%b%b exp=%b%b", c, ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
            end
            compared++;
        end
        if ({ifc1.overrun, ifc2.overrun, ifc1.txd_busy, ifc2.txd_busy} !== {m_ovr[0], m_ovr[1], 2'b00}) begin
            mismatched++;
            $display("FAIL ovr_sticky got=%b exp=%b%b00",
                     {ifc1.overrun, ifc2.overrun, ifc1.txd_busy, ifc2.txd_busy}, m_ovr[0], m_ovr[1]);
        end
        compared++;
    endtask

    task automatic test_stop_bits();
        logic [22:0] got1, got2, exp1, exp2;
        exp1 = '1; exp1[0] = 1'b0; exp1[10] = 1'b0;
        exp2 = '1; exp2[0] = 1'b0; exp2[11] = 1'b0;
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 23; i++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b0, 8'h00, c == 0);
                if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                    mismatched++;
                    $display("FAIL stop_txd bit=%0d cyc=%0d got=%b%b exp=%b%b", i, c,
                             ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
                end
                compared++;
                if (c == 0) begin got1[i] = ifc1.txd; got2[i] = ifc2.txd; end
            end
        end
        if (got1 !== exp1 || got2 !== exp2) begin
            mismatched++;
            $display("FAIL stop_pattern got=%b/%b exp=%b/%b", got1, got2, exp1, exp2);
        end
        compared++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 10; c++) begin
                step(1'b0, 8'h00, c == 0);
                if (ifc1.txd !== m_txd[0] || ifc2.txd !== m_txd[1]) begin
                    mismatched++;
                    $display("FAIL mid_txd bit=%0d got=%b%b exp=%b%b", i, ifc1.txd, ifc2.txd, m_txd[0], m_txd[1]);
                end
                compared++;
                if (i == 5 && c == 4) break;
            end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if ({ifc1.txd, ifc1.level, ifc1.overrun, ifc1.txd_busy, ifc2.txd, ifc2.level, ifc2.txd_busy} !==
            {1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset got=%b exp=1_000_0_0_1_000_0",
                     {ifc1.txd, ifc1.level, ifc1.overrun, ifc1.txd_busy, ifc2.txd, ifc2.level, ifc2.txd_busy});
        end
        compared++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            step(1'b0, 8'h00, (c % 10) == 0);
            if ({ifc1.txd, ifc1.txd_busy, ifc2.txd, ifc2.txd_busy} !== {m_txd[0], 1'b0, m_txd[1], 1'b0}) begin
                mismatched++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b0%b0", c,
                         {ifc1.txd, ifc1.txd_busy, ifc2.txd, ifc2.txd_busy}, m_txd[0], m_txd[1]);
            end
            compared++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_random();
        test_back_to_back();
        test_overrun();
        test_stop_bits();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached compared=%0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
